// File: rtl/adc_capture_pkg.sv
// Shared widths and default divider constants for the ADC capture path and timebase.
package adc_capture_pkg;

    localparam int ADC_W        = 8;
    localparam int TIME_W       = 32;
    localparam int AVG_LOG2     = 4;
    localparam int ACC_W        = ADC_W + AVG_LOG2;
    localparam int MS_PER_10MS  = 10;

    localparam int ADC_HALF_DEF = 25;
    localparam int US10_DIV_DEF = 500;
    localparam int MS_DIV_DEF   = 50000;
    localparam int DISP_MS_DEF  = 100;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_capture_path_tick_gen.sv
// Free-running 0..N-1 counter; pulse is high for the single cycle the counter sits at N-1.
module tick_gen
    import adc_capture_pkg::*;
#(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pulse
);

    localparam int            W    = cnt_width(N);
    localparam logic [W-1:0]  LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pulse = (cnt_q == LAST);

endmodule

// File: rtl/adc_capture_path.sv
// Timebase (10 us / 1 ms ticks, uptime counters) plus ADC clock generation, capture, DAC loopback
// and display latch. Define ADC_AVG_EN to display a 16-sample average instead of the raw sample.
module adc_capture_path
    import adc_capture_pkg::*;
#(
    parameter int ADC_HALF = ADC_HALF_DEF,
    parameter int US10_DIV = US10_DIV_DEF,
    parameter int MS_DIV   = MS_DIV_DEF,
    parameter int DISP_MS  = DISP_MS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADC_W-1:0]  adc_data,
    output logic              adc_clk,
    output logic [ADC_W-1:0]  adc_value,
    output logic              sample_valid,
    output logic [ADC_W-1:0]  dac_value,
    output logic [ADC_W-1:0]  disp_value,
    output logic              tick_10us,
    output logic              tick_1ms,
    output logic [TIME_W-1:0] time_ms,
    output logic [TIME_W-1:0] time_10ms
);

    localparam int               DEC_W     = cnt_width(MS_PER_10MS);
    localparam logic [DEC_W-1:0] DEC_LAST  = DEC_W'(MS_PER_10MS - 1);
    localparam int               DISP_W    = cnt_width(DISP_MS);
    localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(DISP_MS - 1);

    logic half_tick;
    logic capture;
    logic disp_latch;
    logic [ADC_W-1:0] disp_src;

    tick_gen #(.N(US10_DIV)) u_tick_10us (.clk(clk), .rst_n(rst_n), .pulse(tick_10us));
    tick_gen #(.N(MS_DIV))   u_tick_1ms  (.clk(clk), .rst_n(rst_n), .pulse(tick_1ms));
    tick_gen #(.N(ADC_HALF)) u_adc_half  (.clk(clk), .rst_n(rst_n), .pulse(half_tick));

    logic              adc_clk_q,      adc_clk_d;
    logic [ADC_W-1:0]  adc_value_q,    adc_value_d;
    logic              sample_valid_q, sample_valid_d;
    logic [ADC_W-1:0]  dac_value_q,    dac_value_d;
    logic [ADC_W-1:0]  disp_value_q,   disp_value_d;
    logic [TIME_W-1:0] time_ms_q,      time_ms_d;
    logic [TIME_W-1:0] time_10ms_q,    time_10ms_d;
    logic [DEC_W-1:0]  decade_q,       decade_d;
    logic [DISP_W-1:0] disp_cnt_q,     disp_cnt_d;

    // The bus is source-synchronous to adc_clk: sample on the edge that drives it low.
    assign capture    = half_tick && adc_clk_q;
    assign disp_latch = tick_1ms && (disp_cnt_q == DISP_LAST);

    always_comb begin
        adc_clk_d      = adc_clk_q ^ half_tick;
        adc_value_d    = adc_value_q;
        sample_valid_d = capture;
        dac_value_d    = dac_value_q;
        disp_value_d   = disp_value_q;
        time_ms_d      = time_ms_q;
        time_10ms_d    = time_10ms_q;
        decade_d       = decade_q;
        disp_cnt_d     = disp_cnt_q;

        if (capture) begin
            adc_value_d = adc_data;
        end
        if (sample_valid_q) begin
            dac_value_d = adc_value_q;
        end

        if (tick_1ms) begin
            time_ms_d = time_ms_q + TIME_W'(1);
            if (decade_q == DEC_LAST) begin
                decade_d    = '0;
                time_10ms_d = time_10ms_q + TIME_W'(1);
            end else begin
                decade_d = decade_q + DEC_W'(1);
            end
            if (disp_cnt_q == DISP_LAST) begin
                disp_cnt_d = '0;
            end else begin
                disp_cnt_d = disp_cnt_q + DISP_W'(1);
            end
        end

        // disp_src is the registered value, so a same-cycle capture is not seen by the latch.
        if (disp_latch) begin
            disp_value_d = disp_src;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_clk_q      <= 1'b0;
            adc_value_q    <= '0;
            sample_valid_q <= 1'b0;
            dac_value_q    <= '0;
            disp_value_q   <= '0;
            time_ms_q      <= '0;
            time_10ms_q    <= '0;
            decade_q       <= '0;
            disp_cnt_q     <= '0;
        end else begin
            adc_clk_q      <= adc_clk_d;
            adc_value_q    <= adc_value_d;
            sample_valid_q <= sample_valid_d;
            dac_value_q    <= dac_value_d;
            disp_value_q   <= disp_value_d;
            time_ms_q      <= time_ms_d;
            time_10ms_q    <= time_10ms_d;
            decade_q       <= decade_d;
            disp_cnt_q     <= disp_cnt_d;
        end
    end

`ifdef ADC_AVG_EN
    logic [ACC_W-1:0]    acc_q,     acc_d;
    logic [ACC_W-1:0]    acc_sum;
    logic [AVG_LOG2-1:0] avg_cnt_q, avg_cnt_d;
    logic [ADC_W-1:0]    avg_q,     avg_d;

    // 16 x 255 fits in ACC_W bits, so the running sum can never overflow.
    assign acc_sum = acc_q + {{AVG_LOG2{1'b0}}, adc_data};

    always_comb begin
        acc_d     = acc_q;
        avg_cnt_d = avg_cnt_q;
        avg_d     = avg_q;
        if (capture) begin
            if (avg_cnt_q == '1) begin
                avg_d     = acc_sum[ACC_W-1:AVG_LOG2];
                acc_d     = '0;
                avg_cnt_d = '0;
            end else begin
                acc_d     = acc_sum;
                avg_cnt_d = avg_cnt_q + AVG_LOG2'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            avg_cnt_q <= '0;
            avg_q     <= '0;
        end else begin
            acc_q     <= acc_d;
            avg_cnt_q <= avg_cnt_d;
            avg_q     <= avg_d;
        end
    end

    assign disp_src = avg_q;
`else
    assign disp_src = adc_value_q;
`endif

    assign adc_clk      = adc_clk_q;
    assign adc_value    = adc_value_q;
    assign sample_valid = sample_valid_q;
    assign dac_value    = dac_value_q;
    assign disp_value   = disp_value_q;
    assign time_ms      = time_ms_q;
    assign time_10ms    = time_10ms_q;

endmodule

// File: tb/tb_adc_capture_path.sv
// Directed bench for adc_capture_path with shortened dividers (ADC_HALF=2, US10_DIV=5, MS_DIV=20, DISP_MS=3).
module tb_adc_capture_path;

    logic        clk;
    logic        rst_n;
    logic [7:0]  adc_data;
    logic        adc_clk;
    logic [7:0]  adc_value;
    logic        sample_valid;
    logic [7:0]  dac_value;
    logic [7:0]  disp_value;
    logic        tick_10us;
    logic        tick_1ms;
    logic [31:0] time_ms;
    logic [31:0] time_10ms;

    int checks = 0;
    int errors = 0;

    adc_capture_path #(
        .ADC_HALF(2),
        .US10_DIV(5),
        .MS_DIV  (20),
        .DISP_MS (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .adc_data    (adc_data),
        .adc_clk     (adc_clk),
        .adc_value   (adc_value),
        .sample_valid(sample_valid),
        .dac_value   (dac_value),
        .disp_value  (disp_value),
        .tick_10us   (tick_10us),
        .tick_1ms    (tick_1ms),
        .time_ms     (time_ms),
        .time_10ms   (time_10ms)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          e;
        logic        adc_clk;
        logic [7:0]  adc_value;
        logic        sv;
        logic [7:0]  dac;
        logic        t10;
        logic        t1;
        logic [31:0] tms;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reset is released on a falling edge so the next rising edge is edge 1.
    task automatic reset_dut(input logic [7:0] d);
        @(negedge clk);
        rst_n    = 1'b0;
        adc_data = d;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    int e;
    logic [7:0] ramp;
    logic [7:0] exp_adc;
    logic [7:0] exp_disp;

    initial begin
        // e, adc_clk, adc_value, sample_valid, dac, tick_10us, tick_1ms, time_ms
        vecs[0]  = '{0,  1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 32'd0};
        vecs[1]  = '{1,  1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 32'd0};
        vecs[2]  = '{2,  1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 32'd0};
        vecs[3]  = '{3,  1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 32'd0};
        vecs[4]  = '{4,  1'b0, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0, 32'd0};
        vecs[5]  = '{5,  1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0, 32'd0};
        vecs[6]  = '{6,  1'b1, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0, 32'd0};
        vecs[7]  = '{9,  1'b0, 8'hA5, 1'b0, 8'hA5, 1'b1, 1'b0, 32'd0};
        vecs[8]  = '{19, 1'b1, 8'hA5, 1'b0, 8'hA5, 1'b1, 1'b1, 32'd0};
        vecs[9]  = '{20, 1'b0, 8'hA5, 1'b1, 8'hA5, 1'b0, 1'b0, 32'd1};
        vecs[10] = '{39, 1'b1, 8'hA5, 1'b0, 8'hA5, 1'b1, 1'b1, 32'd1};
        vecs[11] = '{40, 1'b0, 8'hA5, 1'b1, 8'hA5, 1'b0, 1'b0, 32'd2};

        rst_n    = 1'b0;
        adc_data = 8'hA5;
        #12;
        chk("rst_adc_clk",   {31'd0, adc_clk},      32'd0);
        chk("rst_adc_value", {24'd0, adc_value},    32'd0);
        chk("rst_valid",     {31'd0, sample_valid}, 32'd0);
        chk("rst_time_ms",   time_ms,               32'd0);

        // Timebase and capture with 0xA5 held on the bus.
        reset_dut(8'hA5);
        e = 0;
        for (int i = 0; i < 12; i++) begin
            while (e < vecs[i].e) begin
                step();
                e++;
            end
            chk($sformatf("adc_clk@%0d", e),   {31'd0, adc_clk},      {31'd0, vecs[i].adc_clk});
            chk($sformatf("adc_value@%0d", e), {24'd0, adc_value},    {24'd0, vecs[i].adc_value});
            chk($sformatf("valid@%0d", e),     {31'd0, sample_valid}, {31'd0, vecs[i].sv});
            chk($sformatf("dac@%0d", e),       {24'd0, dac_value},    {24'd0, vecs[i].dac});
            chk($sformatf("tick_10us@%0d", e), {31'd0, tick_10us},    {31'd0, vecs[i].t10});
            chk($sformatf("tick_1ms@%0d", e),  {31'd0, tick_1ms},     {31'd0, vecs[i].t1});
            chk($sformatf("time_ms@%0d", e),   time_ms,               vecs[i].tms);
        end
        while (e < 199) begin
            step();
            e++;
        end
        chk("time_10ms@199", time_10ms, 32'd0);
        chk("time_ms@199",   time_ms,   32'd9);
        step();
        e++;
        chk("time_10ms@200", time_10ms, 32'd1);
        chk("time_ms@200",   time_ms,   32'd10);

`ifdef ADC_AVG_EN
        // 8 samples of 0x10 (edges 4..32) then 8 of 0x30 (edges 36..64): average 0x20 ready at edge 64.
        reset_dut(8'h10);
        for (int k = 1; k <= 121; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 32) adc_data = 8'h30;
            if (k == 60)  chk("avg_disp@60",  {24'd0, disp_value}, 32'd0);
            if (k == 119) chk("avg_disp@119", {24'd0, disp_value}, 32'd0);
            if (k == 120) chk("avg_disp@120", {24'd0, disp_value}, 32'h20);
            if (k == 121) chk("avg_dac@121",  {24'd0, dac_value},  32'h30);
        end
`else
        // Ramp one step per sample; display latches every 60 edges and must see the pre-capture value.
        reset_dut(8'h00);
        ramp     = 8'h00;
        exp_adc  = 8'h00;
        exp_disp = 8'h00;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            if (k % 60 == 0) exp_disp = exp_adc;
            if (k % 4 == 0)  exp_adc  = ramp;
            @(negedge clk);
            chk($sformatf("ramp_adc@%0d", k),  {24'd0, adc_value},  {24'd0, exp_adc});
            chk($sformatf("ramp_disp@%0d", k), {24'd0, disp_value}, {24'd0, exp_disp});
            if (k % 4 == 0) begin
                ramp     = ramp + 8'd1;
                adc_data = ramp;
            end
        end
        chk("ramp_disp_final", {24'd0, disp_value}, 32'd43);
`endif

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_adc_value", {24'd0, adc_value},    32'd0);
        chk("async_dac",       {24'd0, dac_value},    32'd0);
        chk("async_disp",      {24'd0, disp_value},   32'd0);
        chk("async_time_ms",   time_ms,               32'd0);
        chk("async_time_10ms", time_10ms,             32'd0);
        chk("async_adc_clk",   {31'd0, adc_clk},      32'd0);
        chk("async_valid",     {31'd0, sample_valid}, 32'd0);

        // time_ms wrap from all-ones.
        reset_dut(8'h00);
        repeat (25) step();
        force dut.time_ms_q = 32'hFFFF_FFFF;
        step();
        release dut.time_ms_q;
        chk("wrap_hold@26", time_ms, 32'hFFFF_FFFF);
        repeat (13) step();
        chk("wrap_tick@39", {31'd0, tick_1ms}, 32'd1);
        chk("wrap_pre@39",  time_ms,           32'hFFFF_FFFF);
        step();
        chk("wrap@40",      time_ms,           32'd0);
        chk("wrap_10ms@40", time_10ms,         32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
